// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: signal bundle for the prefetching instruction-fetch queue.
// Ports (as members):
//   entry_point, redirect, redirect_pc        - boot address and control-flow redirect
//   mem_req, mem_addr, mem_gnt                 - instruction memory request/grant
//   mem_rvalid, mem_rdata                      - in-order memory responses
//   ins_valid, ins, ins_pc, ins_pcp4, ins_ready - instruction stream to decode
// master: the fetch unit; slave: memory plus consumer side.
interface ifetch_queue_if;
    logic        redirect;
    logic [31:0] entry_point;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic [31:0] ins_pcp4;
    logic        ins_ready;

    modport master (
        input  entry_point, redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, ins_ready,
        output mem_req, mem_addr, ins_valid, ins, ins_pc, ins_pcp4
    );

    modport slave (
        output entry_point, redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, ins_ready,
        input  mem_req, mem_addr, ins_valid, ins, ins_pc, ins_pcp4
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: prefetching instruction fetch front end with an in-order FIFO.
// Ports:
//   clk   - clock, all state updates on rising edge
//   rst_n - synchronous active-low reset, loads fetch PC from bus.entry_point
//   bus   - ifetch_queue_if.master: memory request/grant/response port,
//           redirect control and valid/ready instruction output with PC/PC+4
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   tag_pc_q, tag_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic          req, gnt, rsp, push, pop, valid;
    logic [CW:0]   credit;
    logic [31:0]   redir_pc;

    // Credits cover both in-flight and buffered words, so a response can never hit a full FIFO.
    assign credit   = {1'b0, out_q} + {1'b0, count_q};
    assign valid    = count_q != '0;
    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        // Gating with rst_n keeps memory from accepting a request the reset is about to forget.
        req        = rst_n && state_q == RUN && !bus.redirect && credit < LIMIT;
        gnt        = req && bus.mem_gnt;
        rsp        = bus.mem_rvalid && out_q != '0;
        push       = rsp && disc_q == '0 && !bus.redirect;
        pop        = valid && bus.ins_ready;
        out_d      = out_q + CW'(gnt) - CW'(rsp);
        count_d    = count_q + CW'(push) - CW'(pop);
        disc_d     = (rsp && disc_q != '0) ? disc_q - 1'b1 : disc_q;
        fetch_pc_d = gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
        // Responses are in order and stale ones are discarded, so the tag is just a running PC.
        tag_pc_d   = push ? tag_pc_q + 32'd4 : tag_pc_q;
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        state_d    = (state_q == BOOT || (state_q == FLUSH && disc_d == '0)) ? RUN : state_q;
        if (bus.redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redir_pc;
            tag_pc_d   = redir_pc;
            disc_d     = out_d;
            count_d    = '0;
            wr_d       = '0;
            rd_d       = '0;
            state_d    = out_d != '0 ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= {bus.entry_point[31:2], 2'b00};
            tag_pc_q   <= {bus.entry_point[31:2], 2'b00};
            count_q    <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= bus.mem_rdata;
            pc_q[wr_q]   <= tag_pc_q;
        end
    end

    assign bus.mem_req   = req;
    assign bus.mem_addr  = fetch_pc_q;
    assign bus.ins_valid = valid;
    assign bus.ins       = valid ? data_q[rd_q] : '0;
    assign bus.ins_pc    = valid ? pc_q[rd_q] : '0;
    assign bus.ins_pcp4  = valid ? pc_q[rd_q] + 32'd4 : '0;
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue with a variable-latency in-order memory model.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_run = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_gnt = 0;
    int          n_pop = 0;
    logic [31:0] exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] gaddr_q[$];
    logic [31:0] last_pc = 32'h0;
    logic [31:0] wrap_p4 = 32'hDEAD_BEEF;
    logic        nxt_rv = 1'b0;
    logic [31:0] nxt_data = 32'h0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    // Memory model and scoreboard: handshakes are evaluated mid-cycle, responses launched after the edge.
    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (bus.mem_rvalid && pend_q.size() != 0) void'(pend_q.pop_front());
        if (!rst_n) exp_q.delete();
        else begin
            if (bus.ins_valid && bus.ins_ready) begin
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h, no word expected", bus.ins_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.ins, bus.ins_pc, bus.ins_pcp4} !== {word(e), e, e + 32'd4}) begin
                        n_fail++;
                        $display("FAIL sb_word: got ins %h pc %h pcp4 %h, want ins %h pc %h pcp4 %h",
                                 bus.ins, bus.ins_pc, bus.ins_pcp4, word(e), e, e + 32'd4);
                    end
                end
                n_pop++;
                last_pc = bus.ins_pc;
                if (bus.ins_pc == 32'hFFFF_FFFC) wrap_p4 = bus.ins_pcp4;
            end
            if (bus.redirect) exp_q.delete();
            if (bus.mem_req && bus.mem_gnt) begin
                exp_q.push_back(bus.mem_addr);
                pend_q.push_back('{bus.mem_addr, cyc + lat});
                gaddr_q.push_back(bus.mem_addr);
                n_gnt++;
            end
        end
        nxt_rv   = pend_q.size() != 0 && pend_q[0].due <= cyc + 1;
        nxt_data = nxt_rv ? word(pend_q[0].addr) : 32'h0;
    end

    always @(posedge clk) begin
        #1;
        bus.mem_rvalid = nxt_rv;
        bus.mem_rdata  = nxt_data;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        bus.entry_point = 32'h0040_0000;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.mem_gnt     = 1'b1;
        bus.ins_ready   = 1'b1;
        lat   = 1;
        rst_n = 1'b0;
        tick(3);
        n_run++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.ins_valid); end
        n_run++; if (bus.ins !== 32'h0) begin n_fail++; $display("FAIL rst_ins: got %h want 0", bus.ins); end
        n_run++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", bus.ins_pc); end
        n_run++; if (bus.ins_pcp4 !== 32'h0) begin n_fail++; $display("FAIL rst_pcp4: got %h want 0", bus.ins_pcp4); end
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
        gaddr_q.delete();
        rst_n = 1'b1;
        #1;
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", bus.mem_req); end
        tick();
        n_run++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
        n_run++; if (bus.mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL first_addr: got %h want 00400000", bus.mem_addr); end
    endtask

    task automatic test_stream;
        int p0;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (gaddr_q[i] !== 32'h0040_0000 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_addr%0d: got %h want %h", i, gaddr_q[i], 32'h0040_0000 + 32'(4 * i));
            end
        end
        p0 = n_pop;
        tick(10);
        n_run++; if (n_pop - p0 != 10) begin n_fail++; $display("FAIL stream_gapless: got %0d pops want 10", n_pop - p0); end
    endtask

    task automatic test_backpressure;
        int g0, p0;
        bus.ins_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0050_0000;
        tick();
        bus.redirect = 1'b0;
        g0 = n_gnt;
        tick(15);
        n_run++; if (n_gnt - g0 != 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", n_gnt - g0); end
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b want 0", bus.mem_req); end
        n_run++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", bus.ins_valid); end
        n_run++; if (bus.ins_pc !== 32'h0050_0000) begin n_fail++; $display("FAIL bp_head_pc: got %h want 00500000", bus.ins_pc); end
        n_run++; if (bus.ins !== word(32'h0050_0000)) begin n_fail++; $display("FAIL bp_head_ins: got %h want %h", bus.ins, word(32'h0050_0000)); end
        p0 = n_pop;
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        tick(5);
        n_run++; if (n_pop - p0 != 1) begin n_fail++; $display("FAIL bp_one_pop: got %0d want 1", n_pop - p0); end
        n_run++; if (n_gnt - g0 != 5) begin n_fail++; $display("FAIL bp_regrant: got %0d want 5", n_gnt - g0); end
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_again: got %b want 0", bus.mem_req); end
    endtask

    task automatic test_stall;
        bus.mem_gnt   = 1'b0;
        bus.ins_ready = 1'b1;
        tick(6);
        n_run++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req: got %b want 1", bus.mem_req); end
        tick(3);
        n_run++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req_hold: got %b want 1", bus.mem_req); end
        n_run++; if (bus.mem_addr !== 32'h0050_0014) begin n_fail++; $display("FAIL stall_addr: got %h want 00500014", bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        tick(10);
    endtask

    task automatic test_redirect_flush;
        int k, p0;
        lat = 3;
        tick(6);
        k = 0;
        while (pend_q.size() < 3 && k < 40) begin tick(); k++; end
        n_run++; if (k >= 40) begin n_fail++; $display("FAIL flush_setup: got %0d outstanding want 3", pend_q.size()); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0103;
        tick();
        bus.redirect = 1'b0;
        n_run++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", bus.ins_valid); end
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b want 0", bus.mem_req); end
        k = 0;
        while (!bus.mem_req && k < 20) begin tick(); k++; end
        n_run++; if (k >= 20) begin n_fail++; $display("FAIL flush_restart: got no request want one within 20 cycles"); end
        n_run++; if (pend_q.size() != 0) begin n_fail++; $display("FAIL flush_drained: got %0d stale pending want 0", pend_q.size()); end
        n_run++; if (bus.mem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL flush_addr: got %h want 00400100", bus.mem_addr); end
        p0 = n_pop;
        k = 0;
        while (n_pop == p0 && k < 20) begin tick(); k++; end
        n_run++; if (last_pc !== 32'h0040_0100) begin n_fail++; $display("FAIL flush_first_pc: got %h want 00400100", last_pc); end
        tick(8);
    endtask

    task automatic test_redirect_collide;
        int k, p0;
        lat = 1;
        tick(6);
        k = 0;
        while (!(bus.mem_rvalid && bus.ins_valid && bus.ins_ready) && k < 40) begin tick(); k++; end
        n_run++; if (k >= 40) begin n_fail++; $display("FAIL collide_setup: got no rvalid+pop cycle want one"); end
        p0 = n_pop;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0060_0000;
        tick();
        bus.redirect = 1'b0;
        n_run++; if (n_pop - p0 != 1) begin n_fail++; $display("FAIL collide_pop: got %0d want 1", n_pop - p0); end
        n_run++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL collide_empty: got %b want 0", bus.ins_valid); end
        k = 0;
        while (n_pop == p0 + 1 && k < 20) begin tick(); k++; end
        n_run++; if (last_pc !== 32'h0060_0000) begin n_fail++; $display("FAIL collide_first_pc: got %h want 00600000", last_pc); end
        tick(8);
    endtask

    task automatic test_wrap;
        bus.entry_point = 32'hFFFF_FFF8;
        rst_n = 1'b0;
        tick(2);
        gaddr_q.delete();
        rst_n = 1'b1;
        tick(12);
        n_run++; if (gaddr_q.size() < 3) begin n_fail++; $display("FAIL wrap_count: got %0d grants want >=3", gaddr_q.size()); end
        else begin
            n_run++; if (gaddr_q[0] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_a0: got %h want fffffff8", gaddr_q[0]); end
            n_run++; if (gaddr_q[1] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_a1: got %h want fffffffc", gaddr_q[1]); end
            n_run++; if (gaddr_q[2] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_a2: got %h want 00000000", gaddr_q[2]); end
        end
        n_run++; if (wrap_p4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcp4: got %h want 00000000", wrap_p4); end
    endtask

    task automatic test_reset_midstream;
        int k, p0;
        lat = 3;
        bus.entry_point = 32'h0070_0000;
        tick(4);
        k = 0;
        while (pend_q.size() < 2 && k < 40) begin tick(); k++; end
        n_run++; if (k >= 40) begin n_fail++; $display("FAIL mid_setup: got %0d outstanding want 2", pend_q.size()); end
        rst_n = 1'b0;
        tick();
        n_run++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", bus.ins_valid); end
        n_run++; if (bus.ins !== 32'h0) begin n_fail++; $display("FAIL mid_ins: got %h want 0", bus.ins); end
        n_run++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("FAIL mid_pc: got %h want 0", bus.ins_pc); end
        n_run++; if (bus.ins_pcp4 !== 32'h0) begin n_fail++; $display("FAIL mid_pcp4: got %h want 0", bus.ins_pcp4); end
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", bus.mem_req); end
        tick();
        gaddr_q.delete();
        p0 = n_pop;
        rst_n = 1'b1;
        tick(14);
        n_run++; if (gaddr_q.size() == 0 || gaddr_q[0] !== 32'h0070_0000) begin
            n_fail++;
            $display("FAIL mid_restart: got %h want 00700000", gaddr_q.size() == 0 ? 32'hx : gaddr_q[0]);
        end
        n_run++; if (n_pop == p0) begin n_fail++; $display("FAIL mid_deliver: got 0 pops want >0"); end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_redirect_flush();
        test_redirect_collide();
        test_wrap();
        test_reset_midstream();
        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
